// File: rtl/cook_timer_pkg.sv
// Shared constants for the cook_timer block: state encoding, BCD digit width
// and a helper that gives each digit position its rollover value.
package cook_timer_pkg;

  // Width of one BCD digit in bits.
  localparam int unsigned DigitW = 4;

  // State encoding; the numeric codes are visible on state_o.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCook  = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Rollover value of digit position idx (0 = seconds ones).
  // Seconds tens borrow to 5, every other digit borrows to 9.
  function automatic logic [DigitW-1:0] digit_max(input int unsigned idx);
    return (idx == 1) ? 4'd5 : 4'd9;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the cook timer: synchronous clear, shift-in load and
// borrow-chained decrement. The borrow chain is purely combinational so that
// the borrow out of the top digit doubles as an all-digits-zero flag.
module bcd_down_digit
  import cook_timer_pkg::*;
#(
  parameter logic [DigitW-1:0] MAX = 4'd9
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              i_clr,
  input  logic              i_dec,
  input  logic              i_borrow,
  input  logic              i_shift,
  input  logic [DigitW-1:0] i_shift_in,
  output logic [DigitW-1:0] o_q,
  output logic              o_borrow
);

  logic [DigitW-1:0] r_q;

  // Digit register: clear beats shift beats decrement.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_shift) begin
      r_q <= i_shift_in;
    end else if (i_dec && i_borrow) begin
      r_q <= (r_q == '0) ? MAX : r_q - 1'b1;
    end
  end

  // Borrow passes up only through digits that are zero.
  always_comb begin
    o_q      = r_q;
    o_borrow = i_borrow && (r_q == '0);
  end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: keypad entry of a BCD m..m:ss time, start/stop/clear
// commands, door interlock, one-second down counting and a done pulse.
// Optional beeper enabled by defining COOK_TIMER_BEEP_EN.
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int unsigned MIN_DIGITS  = 1,
  parameter int unsigned TICK_DIV    = 1000
`ifdef COOK_TIMER_BEEP_EN
  ,
  parameter int unsigned BEEP_CYCLES = 3000
`endif
) (
  input  logic                                 clk,
  input  logic                                 clrn,
  input  logic                                 key_valid,
  input  logic [DigitW-1:0]                    key_digit,
  input  logic                                 startn,
  input  logic                                 stopn,
  input  logic                                 clearn,
  input  logic                                 door_closed,
  output logic [(MIN_DIGITS+2)*DigitW-1:0]     time_bcd,
  output logic                                 mag,
  output logic                                 done,
`ifdef COOK_TIMER_BEEP_EN
  output logic                                 beep,
`endif
  output logic [1:0]                           state_o
);

  localparam int unsigned N  = MIN_DIGITS + 2;
  localparam int unsigned TW = N * DigitW;
  localparam int unsigned PW = $clog2(TICK_DIV);

  state_e            r_state;
  state_e            w_next;
  logic [PW-1:0]     r_presc;
  logic [PW-1:0]     w_presc_next;
  logic              r_mag;
  logic              r_done;

  logic [DigitW-1:0] w_q [N];
  logic [N:0]        w_borrow;
  logic              w_clr;
  logic              w_shift;
  logic              w_dec;
  logic              w_tick;
  logic              w_nonzero;
  logic              w_is_one;
  logic              w_key_ok;
  logic              w_done_entry;

  // Seconds ones always sees a borrow request; borrow out of the MS digit
  // means every digit is zero.
  assign w_borrow[0] = 1'b1;
  assign w_nonzero   = ~w_borrow[N];
  assign w_is_one    = (time_bcd == TW'(1));
  assign w_key_ok    = key_valid && (key_digit <= 4'd9);
  assign w_tick      = (r_state == StCook) && (r_presc == PW'(TICK_DIV - 1));

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_digit
      logic [DigitW-1:0] w_shift_in;
      if (gi == 0) begin : g_ls
        assign w_shift_in = key_digit;
      end else begin : g_up
        // A key in DONE loads onto a zeroed time, so upper digits take zero.
        assign w_shift_in = (r_state == StDone) ? '0 : w_q[gi-1];
      end

      bcd_down_digit #(
        .MAX(digit_max(gi))
      ) u_digit (
        .clk       (clk),
        .clrn      (clrn),
        .i_clr     (w_clr),
        .i_dec     (w_dec),
        .i_borrow  (w_borrow[gi]),
        .i_shift   (w_shift),
        .i_shift_in(w_shift_in),
        .o_q       (w_q[gi]),
        .o_borrow  (w_borrow[gi+1])
      );

      assign time_bcd[gi*DigitW +: DigitW] = w_q[gi];
    end
  endgenerate

  // Next-state and digit control, commands resolved in priority order:
  // clear, door open, stop, then per-state start/key/tick handling.
  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_shift = 1'b0;
    w_dec   = 1'b0;
    if (!clearn) begin
      w_next = StIdle;
      w_clr  = 1'b1;
    end else if (!door_closed) begin
      // A tick coinciding with the door opening is dropped.
      if (r_state == StCook) begin
        w_next = StPause;
      end
    end else if (!stopn) begin
      unique case (r_state)
        StCook:  w_next = StPause;
        StPause: begin
          w_next = StIdle;
          w_clr  = 1'b1;
        end
        StDone:  w_next = StIdle;
        default: w_next = r_state;
      endcase
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!startn) begin
            if (w_nonzero) begin
              w_next = StCook;
            end
          end else if (w_key_ok) begin
            w_shift = 1'b1;
          end
        end
        StCook: begin
          if (w_tick && w_nonzero) begin
            w_dec = 1'b1;
            if (w_is_one) begin
              w_next = StDone;
            end
          end
        end
        StPause: begin
          if (!startn) begin
            w_next = StCook;
          end
        end
        StDone: begin
          if (startn && w_key_ok) begin
            w_shift = 1'b1;
            w_next  = StIdle;
          end
        end
        default: w_next = StIdle;
      endcase
    end
  end

  // Prescaler runs only while staying in COOK, so every COOK entry restarts it.
  always_comb begin
    w_presc_next = '0;
    if ((r_state == StCook) && (w_next == StCook)) begin
      w_presc_next = w_tick ? '0 : r_presc + 1'b1;
    end
  end

  assign w_done_entry = (w_next == StDone) && (r_state != StDone);

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= StIdle;
      r_presc <= '0;
      r_mag   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_presc <= w_presc_next;
      r_mag   <= (w_next == StCook);
      r_done  <= w_done_entry;
    end
  end

  assign mag     = r_mag;
  assign done    = r_done;
  assign state_o = r_state;

`ifdef COOK_TIMER_BEEP_EN
  localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);

  logic [BW-1:0] r_beep_cnt;
  logic          w_beep_cancel;

  assign w_beep_cancel = !clearn || !stopn || !startn || key_valid;

  // Beep countdown: loaded on DONE entry, cut short by any user command.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_beep_cnt <= '0;
    end else if (w_done_entry) begin
      r_beep_cnt <= BW'(BEEP_CYCLES);
    end else if (w_beep_cancel) begin
      r_beep_cnt <= '0;
    end else if (r_beep_cnt != '0) begin
      r_beep_cnt <= r_beep_cnt - 1'b1;
    end
  end

  assign beep = (r_beep_cnt != '0);
`endif

endmodule

// File: doc/cook_timer.md
COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001 Parameter MIN_DIGITS, default 1: number of BCD minute digits (1..4); total digits N = MIN_DIGITS+2.
REQ-002 Parameter TICK_DIV, default 1000: clk cycles per one-second tick (>=2).
REQ-003 Parameter BEEP_CYCLES, default 3000: beep duration in clk cycles (used only under REQ-030).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 clrn  input  1  asynchronous active-low reset.
REQ-006 key_valid  input  1  one-cycle strobe, keypad digit present.
REQ-007 key_digit  input  4  BCD keypad value; values >9 ignored.
REQ-008 startn, stopn, clearn  input  1 each  synchronous active-low command strobes.
REQ-009 door_closed  input  1  high = door closed.
REQ-010 time_bcd  output  4*N  remaining time, bits [3:0] sec ones, [7:4] sec tens, upper nibbles minutes, LS minute first.
REQ-011 mag  output  1  magnetron enable, registered, high only in COOK.
REQ-012 done  output  1  one-cycle pulse on entry to DONE.
REQ-013 state_o  output  2  current state code.

Function
REQ-014 States IDLE=0, COOK=1, PAUSE=2, DONE=3; one registered state register.
REQ-015 Command priority per cycle: clearn > door open > stopn > startn > key_valid.
REQ-016 clearn low in any state: next state IDLE, time_bcd zeroed.
REQ-017 IDLE + valid key: time_bcd shifted left one nibble, key in sec ones, MS nibble discarded.
REQ-018 Keys ignored in COOK and PAUSE; key in DONE: time zeroed, then key shifted in, next state IDLE.
REQ-019 IDLE + startn low + door_closed + time nonzero: COOK; zero time or door open: remain IDLE.
REQ-020 COOK + door open: PAUSE; COOK + stopn: PAUSE; time held.
REQ-021 PAUSE + startn + door_closed: COOK; PAUSE + stopn: IDLE with time zeroed.
REQ-022 DONE + stopn: IDLE; time stays zero.
REQ-023 Prescaler counts 0..TICK_DIV-1 only in COOK, held at 0 in other states; tick on count TICK_DIV-1, first tick TICK_DIV cycles after COOK entry.
REQ-024 Tick decrement: sec ones 0->9 with borrow; sec tens 0->5 with borrow; minute digits 0->9 with borrow; entered sec tens 6..9 are not normalised and count down normally.
REQ-025 Tick when time equals 1 (only sec ones = 1): time becomes 0, next state DONE, mag low same edge, done high one cycle.
REQ-026 Tick and door open in same cycle: no decrement, PAUSE.
REQ-027 time_bcd never decrements below zero; no wrap to max.

Reset
REQ-028 clrn low: state IDLE, time_bcd 0, prescaler 0, mag 0, done 0, beep 0, asynchronously.
REQ-029 Reset mid-COOK drops mag immediately without waiting for clk.

Configuration
REQ-030 COOK_TIMER_BEEP_EN defined: extra output beep (1 bit) high for BEEP_CYCLES cycles starting on DONE entry, cancelled by clearn, stopn, key or startn.
REQ-031 COOK_TIMER_BEEP_EN undefined: no beep port, no beep counter; all other behaviour identical.

Structure
REQ-032 Package cook_timer_pkg holds the state encoding constants and the BCD digit width constant.
REQ-033 One sub-module bcd_down_digit (parameter MAX, borrow in/out, load, shift in) instantiated N times via generate.

Verification
REQ-034 MIN_DIGITS=1, TICK_DIV=4: keys 1,3,0 then startn -> mag high, time 1:30, after 4 cycles 1:29, after 8 cycles 1:28.
REQ-035 Load 0:01, start -> 4 cycles later time 0:00, done one-cycle pulse, mag 0, state DONE.
REQ-036 Cooking at 1:00, tick -> 0:59; load 0:75 and run -> counts 0:74...0:70, 0:69.
REQ-037 Door opens mid-COOK, same cycle as tick -> PAUSE, time unchanged; door closes, startn -> COOK, prescaler restarts from 0.
REQ-038 clearn and startn together in PAUSE -> IDLE, time 0; startn with time 0 -> stays IDLE, mag 0.
REQ-039 clrn asserted mid-COOK between edges -> mag, time_bcd, state zero immediately; with COOK_TIMER_BEEP_EN, beep high BEEP_CYCLES after DONE, stopn clears it next cycle.
